// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the main-memory Avalon arbiter.
// Master index constants fix which port of the interconnect lands on which arbiter input.
package avalon_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int DEF_NM = 3;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    localparam int IBUS  = 0;
    localparam int DBUS  = 1;
    localparam int DEBUG = 2;

endpackage

// File: rtl/avalon_ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping.
// Zero latency, no backpressure; the request vector is doubled so the wrap becomes a plain priority encode.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          found_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] low_mask;
    logic [2*N-1:0] masked;

    always_comb begin
        dbl      = {req_i, req_i};
        low_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(ptr_i)) low_mask[i] = 1'b1;
        end
        masked  = dbl & ~low_mask;
        gnt_o   = '0;
        found_o = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (masked[j] && !found_o) begin
                found_o      = 1'b1;
                gnt_o[j % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/avalon_ram_arbiter.sv
// Round-robin arbiter sharing one Avalon RAM slave among NM masters; grant is held until the transfer completes.
// Zero added latency in IDLE; losers and idle masters always see m_waitrequest=1, the owner sees s_waitrequest.
module avalon_ram_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int NM = DEF_NM,
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NM-1:0]           m_read,
    input  logic [NM-1:0]           m_write,
    input  logic [NM*AW-1:0]        m_address,
    input  logic [NM*(DW/8)-1:0]    m_byte_enable,
    input  logic [NM*DW-1:0]        m_writedata,
    output logic [DW-1:0]           m_readdata,
    output logic [NM-1:0]           m_waitrequest,
    output logic                    s_read,
    output logic                    s_write,
    output logic [AW-1:0]           s_address,
    output logic [DW/8-1:0]         s_byte_enable,
    output logic [DW-1:0]           s_writedata,
    input  logic [DW-1:0]           s_readdata,
    input  logic                    s_waitrequest,
    output logic [NM-1:0]           grant,
    output logic                    proto_err
);

    localparam int PW = $clog2(NM);
    localparam int BW = DW / 8;

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            proto_err_q, proto_err_d;

    logic [NM-1:0]   req;
    logic [NM-1:0]   win_gnt;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   sel_idx;
    logic            active;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] x);
        return (x == PW'(NM - 1)) ? '0 : x + 1'b1;
    endfunction

    assign req = m_read | m_write;

    rr_pick #(.N(NM), .PW(PW)) u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (win_gnt),
        .found_o (win_found)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NM; i++) begin
            if (win_gnt[i]) win_idx = PW'(i);
        end
    end

    // Outputs are gated by rst_n so an asserted reset silences the slave side at once.
    always_comb begin
        sel_idx = owner_q;
        active  = 1'b0;
        if (state_q == IDLE) begin
            if (win_found) begin
                sel_idx = win_idx;
                active  = rst_n;
            end
        end else begin
            active = rst_n & req[owner_q];
        end
    end

    always_comb begin
        grant         = '0;
        m_waitrequest = '1;
        if (active) begin
            grant[sel_idx]         = 1'b1;
            m_waitrequest[sel_idx] = s_waitrequest;
        end
        s_write       = active & m_write[sel_idx];
        s_read        = active & m_read[sel_idx] & ~m_write[sel_idx];
        s_address     = m_address[int'(sel_idx) * AW +: AW];
        s_byte_enable = m_byte_enable[int'(sel_idx) * BW +: BW];
        s_writedata   = m_writedata[int'(sel_idx) * DW +: DW];
        m_readdata    = s_readdata;
        proto_err     = proto_err_q;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        proto_err_d = proto_err_q;
        if (state_q == IDLE) begin
            if (win_found) begin
                if (!s_waitrequest) begin
                    rr_ptr_d = next_idx(win_idx);
                end else begin
                    owner_d = win_idx;
                    state_d = LOCK;
                end
            end
        end else begin
            if (!req[owner_q]) begin
                proto_err_d = 1'b1;
                rr_ptr_d    = next_idx(owner_q);
                state_d     = IDLE;
            end else if (!s_waitrequest) begin
                rr_ptr_d = next_idx(owner_q);
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_avalon_ram_arbiter.sv
// Directed bench for avalon_ram_arbiter with NM=3; the slave side is driven by hand each cycle.
module tb_avalon_ram_arbiter;
    import avalon_arb_pkg::*;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_read, m_write;
    logic [NM*AW-1:0]  m_address;
    logic [NM*4-1:0]   m_byte_enable;
    logic [NM*DW-1:0]  m_writedata;
    logic [DW-1:0]     m_readdata;
    logic [NM-1:0]     m_waitrequest;
    logic              s_read, s_write;
    logic [AW-1:0]     s_address;
    logic [3:0]        s_byte_enable;
    logic [DW-1:0]     s_writedata;
    logic [DW-1:0]     s_readdata;
    logic              s_waitrequest;
    logic [NM-1:0]     grant;
    logic              proto_err;

    int total = 0;
    int bad   = 0;

    avalon_ram_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_address     (m_address),
        .m_byte_enable (m_byte_enable),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_address     (s_address),
        .s_byte_enable (s_byte_enable),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .grant         (grant),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed and checked mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n         = 1'b0;
        m_read        = '0;
        m_write       = '0;
        m_address     = '0;
        m_byte_enable = '0;
        m_writedata   = '0;
        s_readdata    = '0;
        s_waitrequest = 1'b0;
        m_address[IBUS*AW +: AW]  = 32'h0000_0100;
        m_address[DBUS*AW +: AW]  = 32'h0000_0200;
        m_address[DEBUG*AW +: AW] = 32'h0000_0400;
        #3;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_sread", 64'(s_read), 64'h0);
        chk("rst_swrite", 64'(s_write), 64'h0);
        chk("rst_wait", 64'(m_waitrequest), 64'h7);
        chk("rst_perr", 64'(proto_err), 64'h0);
        #10 rst_n = 1'b1;
        cyc();

        // Contention: all three masters, 1-wait slave, rr_ptr starts at 0.
        m_read = 3'b111; s_waitrequest = 1'b1; #1;
        chk("cont_g0a", 64'(grant), 64'h1);
        chk("cont_w0a", 64'(m_waitrequest), 64'h7);
        cyc(); s_waitrequest = 1'b0; #1;
        chk("cont_g0b", 64'(grant), 64'h1);
        chk("cont_w0b", 64'(m_waitrequest), 64'h6);
        cyc(); m_read = 3'b110; s_waitrequest = 1'b1; #1;
        chk("cont_g1a", 64'(grant), 64'h2);
        chk("cont_addr1", 64'(s_address), 64'h200);
        cyc(); s_waitrequest = 1'b0; #1;
        chk("cont_w1b", 64'(m_waitrequest), 64'h5);
        cyc(); m_read = 3'b100; s_waitrequest = 1'b1; #1;
        chk("cont_g2a", 64'(grant), 64'h4);
        chk("cont_w2a", 64'(m_waitrequest), 64'h7);
        cyc(); s_waitrequest = 1'b0; #1;
        chk("cont_w2b", 64'(m_waitrequest), 64'h3);
        cyc(); m_read = 3'b000; #1;
        chk("cont_idle", 64'(grant), 64'h0);

        // Single ibus read at 0x100, 1-wait slave; rr_ptr is back at 0.
        m_read = 3'b001; s_waitrequest = 1'b1; s_readdata = 32'h1234_5678; #1;
        chk("rd_sread", 64'(s_read), 64'h1);
        chk("rd_addr", 64'(s_address), 64'h100);
        chk("rd_grant0", 64'(grant), 64'h1);
        chk("rd_wait0", 64'(m_waitrequest), 64'h7);
        cyc(); s_waitrequest = 1'b0; #1;
        chk("rd_grant1", 64'(grant), 64'h1);
        chk("rd_wait1", 64'(m_waitrequest), 64'h6);
        chk("rd_data", 64'(m_readdata), 64'h1234_5678);
        cyc(); m_read = 3'b000; #1;
        chk("rd_done", 64'(grant), 64'h0);

        // Rotation with a zero-wait slave: dbus twice, then ibus+dbus (ptr 2 wraps to 0).
        m_read = 3'b010; #1;
        chk("rot_d0", 64'(grant), 64'h2);
        chk("rot_d0w", 64'(m_waitrequest), 64'h5);
        cyc(); #1;
        chk("rot_d1", 64'(grant), 64'h2);
        cyc(); m_read = 3'b011; #1;
        chk("rot_wrap", 64'(grant), 64'h1);
        cyc(); #1;
        chk("rot_next", 64'(grant), 64'h2);
        cyc(); m_read = 3'b000; #1;

        // Lock hold: dbus write stalled 3 cycles, ibus arrives in cycle 1. rr_ptr is 2.
        m_write = 3'b010; m_byte_enable[DBUS*4 +: 4] = 4'hF;
        m_writedata[DBUS*DW +: DW] = 32'hDEAD_BEEF; s_waitrequest = 1'b1; #1;
        chk("lk_swrite", 64'(s_write), 64'h1);
        chk("lk_wdata", 64'(s_writedata), 64'hDEAD_BEEF);
        chk("lk_be", 64'(s_byte_enable), 64'hF);
        cyc(); m_read = 3'b001; #1;
        chk("lk_addr1", 64'(s_address), 64'h200);
        chk("lk_grant1", 64'(grant), 64'h2);
        chk("lk_wait1", 64'(m_waitrequest), 64'h7);
        cyc(); #1;
        chk("lk_addr2", 64'(s_address), 64'h200);
        cyc(); s_waitrequest = 1'b0; #1;
        chk("lk_addr3", 64'(s_address), 64'h200);
        chk("lk_wait3", 64'(m_waitrequest), 64'h5);
        cyc(); m_write = 3'b000; s_waitrequest = 1'b1; #1;
        chk("lk_ibus", 64'(grant), 64'h1);
        chk("lk_ibus_addr", 64'(s_address), 64'h100);

        // Protocol error: ibus owns the lock and drops its read while dbus requests.
        cyc(); m_read = 3'b010; #1;
        chk("pe_sread", 64'(s_read), 64'h0);
        chk("pe_wait", 64'(m_waitrequest), 64'h7);
        cyc(); s_waitrequest = 1'b0; #1;
        chk("pe_flag", 64'(proto_err), 64'h1);
        chk("pe_next", 64'(grant), 64'h2);
        cyc(); m_read = 3'b000; #1;
        chk("pe_sticky", 64'(proto_err), 64'h1);

        // Reset in the middle of a locked dbus read.
        m_read = 3'b010; s_waitrequest = 1'b1; #1;
        chk("rs_pre", 64'(grant), 64'h2);
        cyc(); #1;
        rst_n = 1'b0; #1;
        chk("rs_sread", 64'(s_read), 64'h0);
        chk("rs_grant", 64'(grant), 64'h0);
        chk("rs_wait", 64'(m_waitrequest), 64'h7);
        chk("rs_perr", 64'(proto_err), 64'h0);
        #3 rst_n = 1'b1;
        m_read = 3'b011; s_waitrequest = 1'b0; #1;
        chk("rs_first", 64'(grant), 64'h1);
        cyc(); #1;
        chk("rs_second", 64'(grant), 64'h2);
        m_read = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
